sdram_arb: RTL

SDRAM_ARB -- requirements
Module: sdram_arb

---
 rtl/sdram_arb_pkg.sv | 14 +
 rtl/sdram_arb_port.sv | 90 +++++++++
 rtl/sdram_arb.sv | 114 +++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and parameter defaults for the two-port SDRAM byte-port arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W_DEF  = 25;
    localparam int RDY_TMO_DEF = 7;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_LO,
        WAIT_HI
    } state_t;

endpackage

// File: rtl/sdram_arb_port.sv
// One requester port: edge detect on rd/we, request capture, pending flag,
// and the ready/dout registers seen by the requester.
module sdram_arb_port
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              init,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        din_i,
    input  logic              we_i,
    input  logic              rd_i,
    input  logic              done_i,
    input  logic [7:0]        ram_dout_i,
    output logic              pending_o,
    output logic              op_we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        din_o,
    output logic              ready_o,
    output logic [7:0]        dout_o
);

    logic              we_prev_q, rd_prev_q;
    logic              pending_q, pending_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              ready_q, ready_d;
    logic [7:0]        dout_q, dout_d;
    logic              we_edge, req_edge;

    assign we_edge  = we_i & ~we_prev_q;
    assign req_edge = we_edge | (rd_i & ~rd_prev_q);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        pending_d = pending_q;
        op_we_d   = op_we_q;
        addr_d    = addr_q;
        din_d     = din_q;
        ready_d   = ready_q;
        dout_d    = dout_q;

        if (done_i) begin
            if (!op_we_q) dout_d = ram_dout_i;
            pending_d = 1'b0;
            ready_d   = 1'b1;
        end

        // A fresh edge in the completion cycle overrides the completion; otherwise it
        // is only accepted when nothing is pending. A write wins over a same-cycle read.
        if (req_edge && (!pending_q || done_i)) begin
            pending_d = 1'b1;
            ready_d   = 1'b0;
            op_we_d   = we_edge;
            addr_d    = addr_i;
            din_d     = din_i;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        we_prev_q <= we_i;
        rd_prev_q <= rd_i;
        if (init) begin
            pending_q <= 1'b0;
            op_we_q   <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            ready_q   <= 1'b1;
            dout_q    <= '0;
        end else begin
            pending_q <= pending_d;
            op_we_q   <= op_we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            ready_q   <= ready_d;
            dout_q    <= dout_d;
        end
    end

    assign pending_o = pending_q;
    assign op_we_o   = op_we_q;
    assign addr_o    = addr_q;
    assign din_o     = din_q;
    assign ready_o   = ready_q;
    assign dout_o    = dout_q;

endmodule

// File: rtl/sdram_arb.sv
// Round-robin arbiter sharing one SDRAM byte port between two edge-triggered requesters.
module sdram_arb
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int RDY_TMO = RDY_TMO_DEF
) (
    input  logic              clk,
    input  logic              init,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [7:0]        p0_din,
    input  logic [7:0]        p1_din,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic              p0_rd,
    input  logic              p1_rd,
    output logic [7:0]        p0_dout,
    output logic [7:0]        p1_dout,
    output logic              p0_ready,
    output logic              p1_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    output logic              ram_rd,
    input  logic [7:0]        ram_dout,
    input  logic              ram_ready
);

    localparam int TMO_W = $clog2(RDY_TMO + 1);

    state_t            state_q;
    logic              grant_q, last_q;
    logic              ram_we_q, ram_rd_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_din_q;
    logic [TMO_W-1:0]  tmo_q;

    logic [1:0]        pend, op_we, done;
    logic [ADDR_W-1:0] cap_addr [2];
    logic [7:0]        cap_din  [2];
    logic              gnt_sel;

    sdram_arb_port #(.ADDR_W(ADDR_W)) u_port0 (
        .clk(clk), .init(init), .addr_i(p0_addr), .din_i(p0_din), .we_i(p0_we), .rd_i(p0_rd),
        .done_i(done[0]), .ram_dout_i(ram_dout), .pending_o(pend[0]), .op_we_o(op_we[0]),
        .addr_o(cap_addr[0]), .din_o(cap_din[0]), .ready_o(p0_ready), .dout_o(p0_dout)
    );

    sdram_arb_port #(.ADDR_W(ADDR_W)) u_port1 (
        .clk(clk), .init(init), .addr_i(p1_addr), .din_i(p1_din), .we_i(p1_we), .rd_i(p1_rd),
        .done_i(done[1]), .ram_dout_i(ram_dout), .pending_o(pend[1]), .op_we_o(op_we[1]),
        .addr_o(cap_addr[1]), .din_o(cap_din[1]), .ready_o(p1_ready), .dout_o(p1_dout)
    );

    // With both pending, the port not served last wins; otherwise the only pending one.
    assign gnt_sel = (pend[0] && pend[1]) ? ~last_q : pend[1];

    assign done[0] = (state_q == WAIT_HI) && ram_ready && (grant_q == 1'b0);
    assign done[1] = (state_q == WAIT_HI) && ram_ready && (grant_q == 1'b1);

    always_ff @(posedge clk) begin
        if (init) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_rd_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            tmo_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((pend[0] || pend[1]) && ram_ready) begin
                        grant_q    <= gnt_sel;
                        ram_addr_q <= cap_addr[gnt_sel];
                        ram_din_q  <= cap_din[gnt_sel];
                        ram_we_q   <= op_we[gnt_sel];
                        ram_rd_q   <= ~op_we[gnt_sel];
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_we_q <= 1'b0;
                    ram_rd_q <= 1'b0;
                    tmo_q    <= '0;
                    state_q  <= WAIT_LO;
                end
                WAIT_LO: begin
                    // A device that never signals busy must not hang the arbiter.
                    if (!ram_ready || (tmo_q == TMO_W'(RDY_TMO - 1))) begin
                        state_q <= WAIT_HI;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (ram_ready) begin
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_we   = ram_we_q;
    assign ram_rd   = ram_rd_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule
